stripe_demux32: RTL
===================

Name: stripe_demux32

Overview:
- Byte-striping demultiplexer. Sits directly upstream of the two-lane unstripping mux.
- Takes one 32-bit word stream and alternates words onto lane 0 and lane 1: first word of each pair goes to lane 0, second to lane 1.
- Holds the lane-0 word stable while its partner is pending, because the downstream mux only consumes lane 1 while lane 0 is still valid.
- A trailing odd word is completed with a pad word after a timeout, so the pair always closes.

Parameters:
- WIDTH, 32, data width of input and both lanes.
- PAD_TIMEOUT, 4, consecutive idle cycles while a pair is half-filled before the pad word is inserted (legal range 1..15).
- PAD_WORD, 32'h0000_00BC, value driven on lane 1 when padding.
- CNT_W, 4, width of the internal idle counter; must hold PAD_TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- data_in  input  WIDTH  input word.
- valid_in  input  1  data_in qualifier; one word accepted per cycle when high.
- lane_out0  output  WIDTH  lane 0 word (registered).
- lane_out1  output  WIDTH  lane 1 word (registered).
- valid_out0  output  1  lane 0 qualifier.
- valid_out1  output  1  lane 1 qualifier.
- pad_out  output  1  high for the one cycle in which lane_out1 carries PAD_WORD.
- pending  output  1  high while lane 0 holds a word whose partner has not arrived.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on port reset. When reset==0 at a rising edge, all outputs are cleared to 0, sel goes to SEL0 and idle_cnt goes to 0. Reset overrides every other event, including mid-pair: a pending lane-0 word is dropped and no pad is emitted.
- All outputs are registered. A word accepted at edge N is visible just after edge N (latency 1). There is no backpressure; valid_in is always accepted.
- State is sel ∈ {SEL0, SEL1} plus idle_cnt. pending = (sel==SEL1).
- SEL0 with valid_in=1 (opens a pair):
  - lane_out0<=data_in, valid_out0<=1.
  - lane_out1<=0, valid_out1<=0, pad_out<=0.
  - sel<=SEL1, idle_cnt<=0.
- SEL0 with valid_in=0 (idle):
  - lane_out0<=0, lane_out1<=0, valid_out0<=0, valid_out1<=0, pad_out<=0.
- SEL1 with valid_in=1 (closes the pair):
  - lane_out1<=data_in, valid_out1<=1.
  - lane_out0/valid_out0 held.
  - sel<=SEL0, idle_cnt<=0, pad_out<=0.
- SEL1 with valid_in=0:
  - lane_out0/valid_out0 held; valid_out1 stays 0.
  - If idle_cnt==PAD_TIMEOUT-1: lane_out1<=PAD_WORD, valid_out1<=1, pad_out<=1, sel<=SEL0, idle_cnt<=0.
  - Otherwise idle_cnt<=idle_cnt+1.
  - Net effect: the pad appears after exactly PAD_TIMEOUT consecutive idle cycles.
- Gap shorter than PAD_TIMEOUT in SEL1: the next valid word goes to lane 1 normally and the counter resets. Idle cycles need not be contiguous with the lane-0 acceptance.
- pad_out self-clears on the next edge. With PAD_TIMEOUT=1, the pad is inserted on the first idle cycle.
- The cycle after a pair completes (normal or padded), both lanes remain visible. They are then cleared or replaced per the SEL0 rules above.
- Back-to-back words every cycle alternate lanes indefinitely; no bubbles are inserted.

Optional Feature:
- Macro STRIPE_WORD_CNT_EN.
- When defined: adds outputs word_cnt0 [15:0] and word_cnt1 [15:0].
  - Each counts data words placed on its lane; pad words are not counted.
  - Cleared by reset; saturate at 16'hFFFF.
  - Each updates on the same edge as the corresponding lane register.
- When undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with valid_in=1, data_in=32'hFFFFFFFF -> all outputs 0, pending=0.
- Pair: valid_in=1 with 32'hA1A1A1A1 then 32'hB2B2B2B2 -> edge1 lane_out0=A1A1A1A1/valid_out0=1/pending=1; edge2 lane_out1=B2B2B2B2/valid_out1=1, lane_out0 still A1A1A1A1, pending=0.
- Stream: 4 consecutive words 1,2,3,4 then idle -> lanes carry (1,–), (1,2), (3,0), (3,4), then all zero one cycle after idle.
- Odd word with PAD_TIMEOUT=4: word 32'h11 then idle -> lane0=0x11 held 4 cycles; 4th idle edge gives lane_out1=32'hBC, valid_out1=1, pad_out=1 for one cycle; next idle cycle all zero.
- Gap resume: word 0x22, 2 idle cycles, word 0x33 -> no pad, lane_out1=0x33, pad_out never 1. Then reset=0 mid-pair after word 0x44 -> outputs 0, no pad afterwards.
- STRIPE_WORD_CNT_EN: 5 words + pad -> word_cnt0=3, word_cnt1=2.

Source files
------------

// File: rtl/stripe_demux32.sv
// rtl/stripe_demux32.sv - two-lane word striping demux with pad-on-timeout pair closure
// Optional feature macro: STRIPE_WORD_CNT_EN (per-lane data word counters)
module stripe_demux32 #(
  parameter int               WIDTH       = 32,
  parameter int               PAD_TIMEOUT = 4,
  parameter logic [WIDTH-1:0] PAD_WORD    = 'h0000_00BC,
  parameter int               CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] lane_out0,
  output logic [WIDTH-1:0] lane_out1,
  output logic             valid_out0,
  output logic             valid_out1,
  output logic             pad_out,
  output logic             pending
`ifdef STRIPE_WORD_CNT_EN
  ,
  output logic [15:0]      word_cnt0,
  output logic [15:0]      word_cnt1
`endif
);

  typedef enum logic {
    SEL0 = 1'b0,
    SEL1 = 1'b1
  } sel_t;

  localparam logic [CNT_W-1:0] LP_IDLE_LAST = CNT_W'(PAD_TIMEOUT - 1);

  sel_t             r_sel;
  sel_t             w_sel_nxt;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] w_idle_cnt_nxt;
  logic [WIDTH-1:0] r_lane0;
  logic [WIDTH-1:0] r_lane1;
  logic [WIDTH-1:0] w_lane0_nxt;
  logic [WIDTH-1:0] w_lane1_nxt;
  logic             r_valid0;
  logic             r_valid1;
  logic             r_pad;
  logic             w_valid0_nxt;
  logic             w_valid1_nxt;
  logic             w_pad_nxt;
  logic             w_take0;
  logic             w_take1;

  // State and output registers; reset drops any half-filled pair without padding
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sel      <= SEL0;
      r_idle_cnt <= '0;
      r_lane0    <= '0;
      r_lane1    <= '0;
      r_valid0   <= 1'b0;
      r_valid1   <= 1'b0;
      r_pad      <= 1'b0;
    end else begin
      r_sel      <= w_sel_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_lane0    <= w_lane0_nxt;
      r_lane1    <= w_lane1_nxt;
      r_valid0   <= w_valid0_nxt;
      r_valid1   <= w_valid1_nxt;
      r_pad      <= w_pad_nxt;
    end
  end

  // Next-state: open pair on lane 0, close it on lane 1 with data or, after the idle timeout, a pad
  always_comb begin
    w_sel_nxt      = r_sel;
    w_idle_cnt_nxt = r_idle_cnt;
    w_lane0_nxt    = r_lane0;
    w_lane1_nxt    = r_lane1;
    w_valid0_nxt   = r_valid0;
    w_valid1_nxt   = r_valid1;
    w_pad_nxt      = 1'b0;
    w_take0        = 1'b0;
    w_take1        = 1'b0;
    case (r_sel)
      SEL0: begin
        w_lane1_nxt    = '0;
        w_valid1_nxt   = 1'b0;
        w_idle_cnt_nxt = '0;
        if (valid_in) begin
          w_lane0_nxt  = data_in;
          w_valid0_nxt = 1'b1;
          w_sel_nxt    = SEL1;
          w_take0      = 1'b1;
        end else begin
          w_lane0_nxt  = '0;
          w_valid0_nxt = 1'b0;
        end
      end
      SEL1: begin
        // lane 0 stays put so the downstream mux can still consume lane 1 against it
        if (valid_in) begin
          w_lane1_nxt    = data_in;
          w_valid1_nxt   = 1'b1;
          w_sel_nxt      = SEL0;
          w_idle_cnt_nxt = '0;
          w_take1        = 1'b1;
        end else if (r_idle_cnt == LP_IDLE_LAST) begin
          w_lane1_nxt    = PAD_WORD;
          w_valid1_nxt   = 1'b1;
          w_pad_nxt      = 1'b1;
          w_sel_nxt      = SEL0;
          w_idle_cnt_nxt = '0;
        end else begin
          w_valid1_nxt   = 1'b0;
          w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end
      end
      default: begin
        w_sel_nxt      = SEL0;
        w_idle_cnt_nxt = '0;
      end
    endcase
  end

`ifdef STRIPE_WORD_CNT_EN
  logic [15:0] r_word_cnt0;
  logic [15:0] r_word_cnt1;

  // Saturating per-lane data word counters; pad words are not data and are skipped
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_word_cnt0 <= '0;
      r_word_cnt1 <= '0;
    end else begin
      if (w_take0 && (r_word_cnt0 != 16'hFFFF)) begin
        r_word_cnt0 <= r_word_cnt0 + 16'd1;
      end
      if (w_take1 && (r_word_cnt1 != 16'hFFFF)) begin
        r_word_cnt1 <= r_word_cnt1 + 16'd1;
      end
    end
  end

  assign word_cnt0 = r_word_cnt0;
  assign word_cnt1 = r_word_cnt1;
`else
  // Acceptance strobes only feed the optional counters
  logic w_unused_take;
  assign w_unused_take = w_take0 ^ w_take1;
`endif

  assign lane_out0  = r_lane0;
  assign lane_out1  = r_lane1;
  assign valid_out0 = r_valid0;
  assign valid_out1 = r_valid1;
  assign pad_out    = r_pad;
  assign pending    = (r_sel == SEL1);

endmodule
